// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic inter-stage pipeline register:
//   - bit layout of the control bundle (offset/width per field)
//   - default control width and the all-zero bubble control word
//   - the per-cycle action type and the helper that applies the
//     flush > hazard > normal priority
// Build option: macro PIPE_SKID_EN (used by pipeline_stage_reg) adds one
// skid entry behind the output slot.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Control bundle field layout (LSB first)
  localparam int REGWRITE_OFF = 0;
  localparam int REGWRITE_W   = 1;
  localparam int ALUSRC1_OFF  = 1;
  localparam int ALUSRC1_W    = 1;
  localparam int MEMREAD_OFF  = 2;
  localparam int MEMREAD_W    = 2;
  localparam int MEMWRITE_OFF = 4;
  localparam int MEMWRITE_W   = 2;
  localparam int REGDEST_OFF  = 6;
  localparam int REGDEST_W    = 2;
  localparam int MEMTOREG_OFF = 8;
  localparam int MEMTOREG_W   = 3;
  localparam int ALUOP_OFF    = 11;
  localparam int ALUOP_W      = 5;

  localparam int CTRL_W_DEF = 16;

  // A bubble must never assert RegWrite/MemWrite, so it is all zeros.
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_HAZARD = 2'd1,
    ACT_FLUSH  = 2'd2
  } stage_act_e;

  // Flush wins over hazard; reset is handled separately in the registers.
  function automatic stage_act_e stage_action(input logic flush, input logic hazard);
    if (flush)  return ACT_FLUSH;
    if (hazard) return ACT_HAZARD;
    return ACT_NORMAL;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry skid buffer (valid + data + ctrl) sitting behind the output slot
// of pipeline_stage_reg. Only instantiated when PIPE_SKID_EN is defined.
// Ports:
//   Clk      clock
//   Rst      synchronous active-high reset (empties the entry)
//   clr_i    flush: empties the entry, overrides write/read
//   wr_i     capture data_i/ctrl_i (caller only writes when empty)
//   rd_i     entry moved out this cycle, becomes empty
//   data_i   data bundle to capture
//   ctrl_i   control bundle to capture
//   valid_o  entry holds an instruction
//   data_o   stored data bundle (zero when empty)
//   ctrl_o   stored control bundle (zero when empty)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(BUBBLE_CTRL);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = BUBBLE;
    end else if (wr_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = BUBBLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake, hazard stall with bubble insertion, flush, and a
// saturating stall-cycle counter. One cycle of latency.
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer so inReady
// no longer depends combinationally on outReady.
// Ports:
//   Clk            clock
//   Rst            synchronous active-high reset
//   inValid        upstream holds a valid instruction
//   inReady        stage accepts this cycle (transfer-in = inValid & inReady)
//   inData/inCtrl  data / control bundles from upstream
//   inHazard       hazard: refuse input, insert a bubble when possible
//   inHazardFlush  flush: discard the stage contents
//   outValid       output slot holds a valid instruction
//   outReady       downstream accepts (transfer-out = outValid & outReady)
//   outData        registered data bundle
//   outCtrl        registered control bundle, zero whenever outValid=0
//   outStallCount  saturating count of cycles with inValid & ~inReady
// -----------------------------------------------------------------------------
module pipeline_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic              inHazard,
  input  logic              inHazardFlush,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [CNT_W-1:0]  outStallCount
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(BUBBLE_CTRL);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              in_ready;
  logic              xfer_in;
  logic              drain;
  logic              stall;
  stage_act_e        act;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_wr;
  logic              skid_rd;

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .Clk     (Clk),
    .Rst     (Rst),
    .clr_i   (inHazardFlush),
    .wr_i    (skid_wr),
    .rd_i    (skid_rd),
    .data_i  (inData),
    .ctrl_i  (inCtrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

  // Registered-only ready: a free skid entry absorbs one beat of back-pressure.
  assign in_ready = ~skid_valid & ~inHazard & ~inHazardFlush;
`else
  assign skid_valid = 1'b0;
  assign skid_data  = '0;
  assign skid_ctrl  = BUBBLE;

  // No skid entry exists, so the write/read strobes have no consumer.
  logic unused_skid;
  assign unused_skid = skid_wr | skid_rd;

  assign in_ready = ~inHazard & ~inHazardFlush & (~out_valid_q | outReady);
`endif

  assign act     = stage_action(inHazardFlush, inHazard);
  assign xfer_in = inValid & in_ready;
  assign drain   = out_valid_q & outReady;
  assign stall   = inValid & ~in_ready;

  // Output slot next state. The same decision tree serves both builds: without
  // the skid, skid_valid is constant 0 and a transfer-in never coincides with
  // a held output slot, so the skid branches are unreachable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_wr     = 1'b0;
    skid_rd     = 1'b0;
    case (act)
      ACT_FLUSH: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_ctrl_d  = BUBBLE;
      end
      ACT_HAZARD: begin
        if (skid_valid) begin
          // Skid must empty before a bubble can be placed.
          if (outReady) begin
            out_valid_d = 1'b1;
            out_data_d  = skid_data;
            out_ctrl_d  = skid_ctrl;
            skid_rd     = 1'b1;
          end
        end else if (~out_valid_q | outReady) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_ctrl_d  = BUBBLE;
        end
      end
      default: begin
        if (skid_valid) begin
          // Oldest entry first; upstream is refused while the skid is full.
          if (outReady) begin
            out_valid_d = 1'b1;
            out_data_d  = skid_data;
            out_ctrl_d  = skid_ctrl;
            skid_rd     = 1'b1;
          end
        end else if (xfer_in) begin
          if (out_valid_q & ~outReady) begin
            skid_wr = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = inData;
            out_ctrl_d  = inCtrl;
          end
        end else if (drain) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_ctrl_d  = BUBBLE;
        end
      end
    endcase
  end

  // Saturating stall counter; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign inReady       = in_ready;
  assign outValid      = out_valid_q;
  assign outData       = out_data_q;
  assign outCtrl       = out_ctrl_q;
  assign outStallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_reg
// Directed scenarios followed by randomized stimulus. The reference model sees
// the stage as an ordered queue of in-flight instructions (capacity 1, or 2
// with PIPE_SKID_EN); the head of the queue is the expected output slot.
// A second instance with CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_reg;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        inValid;
  logic [31:0] inData;
  logic [15:0] inCtrl;
  logic        inHazard;
  logic        inHazardFlush;
  logic        outReady;

  wire         inReady;
  wire         outValid;
  wire  [31:0] outData;
  wire  [15:0] outCtrl;
  wire  [15:0] outStallCount;

  wire         s_inReady;
  wire         s_outValid;
  wire  [31:0] s_outData;
  wire  [15:0] s_outCtrl;
  wire  [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: in-flight entries {ctrl, data}, oldest first.
  logic [47:0] mq[$];
  int unsigned mcnt;

  always #5 Clk = ~Clk;

  pipeline_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .inValid       (inValid),
    .inReady       (inReady),
    .inData        (inData),
    .inCtrl        (inCtrl),
    .inHazard      (inHazard),
    .inHazardFlush (inHazardFlush),
    .outValid      (outValid),
    .outReady      (outReady),
    .outData       (outData),
    .outCtrl       (outCtrl),
    .outStallCount (outStallCount)
  );

  pipeline_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(2)) dut_sat (
    .Clk           (Clk),
    .Rst           (Rst),
    .inValid       (inValid),
    .inReady       (s_inReady),
    .inData        (inData),
    .inCtrl        (inCtrl),
    .inHazard      (inHazard),
    .inHazardFlush (inHazardFlush),
    .outValid      (s_outValid),
    .outReady      (outReady),
    .outData       (s_outData),
    .outCtrl       (s_outCtrl),
    .outStallCount (s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input logic hz, input logic fl, input logic r);
`ifdef PIPE_SKID_EN
    return !hz && !fl && (mq.size() < 2);
`else
    return !hz && !fl && ((mq.size() == 0) || r);
`endif
  endfunction

  // One clock: drive inputs, check at negedge, advance the model at posedge.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic [15:0] c, input logic hz, input logic fl,
                      input logic r);
    logic        rdy;
    logic [47:0] head;
    Rst           = rst;
    inValid       = v;
    inData        = d;
    inCtrl        = c;
    inHazard      = hz;
    inHazardFlush = fl;
    outReady      = r;
    @(negedge Clk);
    rdy  = model_ready(hz, fl, r);
    head = (mq.size() > 0) ? mq[0] : 48'h0;
    check("inReady",  inReady,       rdy);
    check("outValid", outValid,      mq.size() > 0);
    check("outData",  outData,       head[31:0]);
    check("outCtrl",  outCtrl,       head[47:32]);
    check("stallCnt", outStallCount, (mcnt > 65535) ? 65535 : mcnt);
    check("satCnt",   s_cnt,         (mcnt > 3) ? 3 : mcnt);
    check("satData",  s_outData,     head[31:0]);
    check("satValid", s_outValid & s_inReady, (mq.size() > 0) & rdy);
    check("satCtrl",  s_outCtrl,     head[47:32]);
    if (outValid && r && !rst)
      $display("xfer-out data=%h ctrl=%h", outData, outCtrl);
    @(posedge Clk);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (v && !rdy) mcnt++;
      if (fl) begin
        mq.delete();
      end else begin
        if ((mq.size() > 0) && r) void'(mq.pop_front());
        if (v && rdy) mq.push_back({c, d});
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    Rst = 1'b1; inValid = 1'b0; inData = '0; inCtrl = '0;
    inHazard = 1'b0; inHazardFlush = 1'b0; outReady = 1'b1;
    mcnt = 0;
    @(posedge Clk);
    #1;

    // Reset then stream 1,2,3
    do_reset();
    do_reset();
    step(1'b0, 1'b1, 32'd1, 16'h0011, 1'b0, 1'b0, 1'b1);
    check("stream_first", outData, 32'd1);
    step(1'b0, 1'b1, 32'd2, 16'h0011, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'd3, 16'h0011, 1'b0, 1'b0, 1'b1);
    check("stream_last", outData, 32'd3);
    step(1'b0, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Hazard for one cycle on a valid 32'h5
    do_reset();
    step(1'b0, 1'b1, 32'h5, 16'h0022, 1'b1, 1'b0, 1'b1);
    check("hz_bubble", outValid, 1'b0);
    step(1'b0, 1'b1, 32'h5, 16'h0022, 1'b0, 1'b0, 1'b1);
    check("hz_accept", outData, 32'h5);
    check("hz_cnt", outStallCount, 16'd1);

    // Flush while back-pressured holding 32'hA
    do_reset();
    step(1'b0, 1'b1, 32'hA, 16'h0033, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("fl_valid", outValid, 1'b0);
    check("fl_data",  outData,  32'h0);
    check("fl_ctrl",  outCtrl,  16'h0);

    // Back-pressure: hold 32'h7 for 3 cycles while 32'h8 waits
    do_reset();
    step(1'b0, 1'b1, 32'h7, 16'h0044, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h8, 16'h0055, 1'b0, 1'b0, 1'b0);
    check("bp_hold", outData, 32'h7);
`ifdef PIPE_SKID_EN
    check("bp_cnt", outStallCount, 16'd2);
`else
    check("bp_cnt", outStallCount, 16'd3);
`endif
    step(1'b0, 1'b1, 32'h8, 16'h0055, 1'b0, 1'b0, 1'b1);
    check("bp_release", outData, 32'h8);
    step(1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("bp_nodup", outValid, 1'b0);

    // Flush + hazard together, then 5 hazard stalls to saturate CNT_W=2
    do_reset();
    step(1'b0, 1'b1, 32'h9, 16'h0066, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h10, 16'h0077, 1'b1, 1'b1, 1'b0);
    check("flhz_valid", outValid, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 32'h11, 16'h0077, 1'b1, 1'b0, 1'b1);
    check("sat_cnt", s_cnt, 2'd3);
    check("sat_main_cnt", outStallCount, 16'd6);

    // Reset while the slot (and skid) are occupied
    do_reset();
    step(1'b0, 1'b1, 32'h20, 16'h0088, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h21, 16'h0099, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h22, 16'h00AA, 1'b0, 1'b0, 1'b0);
    check("rst_valid", outValid, 1'b0);
    check("rst_data",  outData,  32'h0);
    check("rst_cnt",   outStallCount, 16'd0);
    check("rst_ready", inReady, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           16'($urandom),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
